// File: rtl/mem_access_unit.sv
// Load/store bus adapter: runs one handshaked word-wide bus transaction per accepted op,
// with byte enables, store lane replication, load extension, misalign and timeout status.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  read_op,
  input  logic [1:0]  write_op,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        misaligned,
  output logic        timeout,
  output logic [29:0] bus_addr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic [1:0]  state_dbg
);

  // Handshake: bus_req stays high with stable addr/we/be/wdata until bus_ack is
  // sampled high on a rising edge; that edge completes the transaction.

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] rdata_d;
  logic        done_d, mis_d, to_d;
  logic [29:0] bus_addr_d;
  logic        bus_req_d, bus_we_d;
  logic [3:0]  bus_be_d;
  logic [31:0] bus_wdata_d;

  logic        st_valid, ld_valid, acc_word, acc_half, acc_mis;
  logic [3:0]  acc_be;
  logic [31:0] acc_wdata;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_val;

  // Store takes priority over a simultaneous load.
  always_comb begin
    st_valid  = (write_op != 2'b11);
    ld_valid  = (read_op == 3'b000) || (read_op == 3'b001) || (read_op == 3'b010) ||
                (read_op == 3'b100) || (read_op == 3'b101);
    acc_word  = st_valid ? (write_op == 2'b10) : (read_op == 3'b010);
    acc_half  = st_valid ? (write_op == 2'b01) : (read_op[1:0] == 2'b01);
    acc_mis   = acc_word ? (addr[1:0] != 2'b00) : (acc_half ? addr[0] : 1'b0);
    acc_be    = 4'b1111;
    acc_wdata = wdata;
    if (st_valid && write_op == 2'b00) begin
      acc_be    = 4'b0001 << addr[1:0];
      acc_wdata = {4{wdata[7:0]}};
    end else if (st_valid && write_op == 2'b01) begin
      acc_be    = 4'b0011 << addr[1:0];
      acc_wdata = {2{wdata[15:0]}};
    end
  end

  always_comb begin
    sel_byte = 8'(bus_rdata >> {lane_q, 3'b000});
    sel_half = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (op_q)
      3'b000:  load_val = {{24{sel_byte[7]}}, sel_byte};
      3'b100:  load_val = {24'd0, sel_byte};
      3'b001:  load_val = {{16{sel_half[15]}}, sel_half};
      3'b101:  load_val = {16'd0, sel_half};
      default: load_val = bus_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    lane_d      = lane_q;
    rdata_d     = rdata;
    done_d      = 1'b0;
    mis_d       = misaligned;
    to_d        = timeout;
    bus_addr_d  = bus_addr;
    bus_req_d   = 1'b0;
    bus_we_d    = bus_we;
    bus_be_d    = bus_be;
    bus_wdata_d = bus_wdata;
    case (state_q)
      IDLE: begin
        if (st_valid || ld_valid) begin
          if (acc_mis) begin
            state_d = DONE;
            done_d  = 1'b1;
            mis_d   = 1'b1;
            to_d    = 1'b0;
          end else begin
            state_d     = REQ;
            cnt_d       = 8'd0;
            op_d        = read_op;
            lane_d      = addr[1:0];
            bus_addr_d  = addr[31:2];
            bus_req_d   = 1'b1;
            bus_we_d    = st_valid;
            bus_be_d    = acc_be;
            bus_wdata_d = acc_wdata;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + 8'd1;
        if (bus_ack) begin
          state_d = DONE;
          done_d  = 1'b1;
          mis_d   = 1'b0;
          to_d    = 1'b0;
          if (!bus_we) rdata_d = load_val;
        end else if (cnt_q + 8'd1 == TO_LIMIT) begin
          state_d = DONE;
          done_d  = 1'b1;
          mis_d   = 1'b0;
          to_d    = 1'b1;
        end else begin
          bus_req_d = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      op_q       <= 3'b011;
      lane_q     <= 2'b00;
      rdata      <= 32'd0;
      done       <= 1'b0;
      misaligned <= 1'b0;
      timeout    <= 1'b0;
      bus_addr   <= 30'd0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_be     <= 4'd0;
      bus_wdata  <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      lane_q     <= lane_d;
      rdata      <= rdata_d;
      done       <= done_d;
      misaligned <= mis_d;
      timeout    <= to_d;
      bus_addr   <= bus_addr_d;
      bus_req    <= bus_req_d;
      bus_we     <= bus_we_d;
      bus_be     <= bus_be_d;
      bus_wdata  <= bus_wdata_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table of single accesses plus
// hand sequences for reset, stray ack, invalid ops and ops arriving in DONE.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] addr, wdata;
  logic [2:0]  read_op;
  logic [1:0]  write_op;
  logic [31:0] rdata;
  logic        busy, done, misaligned, timeout;
  logic [29:0] bus_addr;
  logic        bus_req, bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata, bus_rdata;
  logic        bus_ack;
  logic [1:0]  state_dbg;

  int n_pass = 0;
  int n_total = 0;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .wdata(wdata),
    .read_op(read_op), .write_op(write_op), .rdata(rdata), .busy(busy),
    .done(done), .misaligned(misaligned), .timeout(timeout),
    .bus_addr(bus_addr), .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  rop;
    logic [1:0]  wop;
    logic [31:0] a;
    logic [31:0] wd;
    int          ack_at;   // REQ cycle in which ack is driven; 0 = never
    logic [31:0] brd;
    int          lat;      // edges from acceptance until done is visible
    int          reqs;
    logic        mis;
    logic        to;
    logic [31:0] rd;
    logic        we;
    logic [3:0]  be;
    logic [31:0] bwd;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(logic [2:0] rop, logic [1:0] wop, logic [31:0] a,
                              logic [31:0] wd, int ack_at, logic [31:0] brd, int lat,
                              int reqs, logic mis, logic to, logic [31:0] rd,
                              logic we, logic [3:0] be, logic [31:0] bwd);
    vec_t v;
    v.rop = rop; v.wop = wop; v.a = a; v.wd = wd; v.ack_at = ack_at; v.brd = brd;
    v.lat = lat; v.reqs = reqs; v.mis = mis; v.to = to; v.rd = rd;
    v.we = we; v.be = be; v.bwd = bwd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic idle_inputs();
    read_op  = 3'b011;
    write_op = 2'b11;
    addr     = 32'hFFFF_FFFF;
    wdata    = 32'h1357_9BDF;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int n = 0;
    int reqs = 0;
    bit got = 0;
    @(negedge clk);
    read_op = v.rop; write_op = v.wop; addr = v.a; wdata = v.wd;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      idle_inputs();
      bus_ack   = 1'b0;
      bus_rdata = 32'hBAD0_BAD0;
      if (done) begin
        got = 1;
      end else if (bus_req) begin
        reqs++;
        chk($sformatf("v%0d bus_addr", idx), 32'(bus_addr), 32'(v.a[31:2]));
        chk($sformatf("v%0d bus_we", idx), 32'(bus_we), 32'(v.we));
        chk($sformatf("v%0d bus_be", idx), 32'(bus_be), 32'(v.be));
        if (v.we) chk($sformatf("v%0d bus_wdata", idx), bus_wdata, v.bwd);
        if (v.ack_at == reqs) begin
          bus_ack   = 1'b1;
          bus_rdata = v.brd;
        end
      end
    end
    bus_ack = 1'b0;
    chk($sformatf("v%0d done_seen", idx), 32'(got), 32'd1);
    chk($sformatf("v%0d latency", idx), 32'(n), 32'(v.lat));
    chk($sformatf("v%0d req_cycles", idx), 32'(reqs), 32'(v.reqs));
    chk($sformatf("v%0d misaligned", idx), 32'(misaligned), 32'(v.mis));
    chk($sformatf("v%0d timeout", idx), 32'(timeout), 32'(v.to));
    chk($sformatf("v%0d rdata", idx), rdata, v.rd);
    chk($sformatf("v%0d req_low_at_done", idx), 32'(bus_req), 32'd0);
  endtask

  initial begin
    // rop  wop   addr   wdata  ack brd  lat reqs mis to rdata  we be bus_wdata
    vecs[0]  = mk(3'b010, 2'b11, 32'h100, 32'h0, 1, 32'hDEADBEEF, 2, 1, 0, 0, 32'hDEADBEEF, 0, 4'b1111, 32'h0);
    vecs[1]  = mk(3'b000, 2'b11, 32'h103, 32'h0, 1, 32'h80112233, 2, 1, 0, 0, 32'hFFFFFF80, 0, 4'b1111, 32'h0);
    vecs[2]  = mk(3'b100, 2'b11, 32'h103, 32'h0, 1, 32'h80112233, 2, 1, 0, 0, 32'h00000080, 0, 4'b1111, 32'h0);
    vecs[3]  = mk(3'b101, 2'b11, 32'h102, 32'h0, 1, 32'h80112233, 2, 1, 0, 0, 32'h00008011, 0, 4'b1111, 32'h0);
    vecs[4]  = mk(3'b001, 2'b11, 32'h102, 32'h0, 1, 32'h80112233, 2, 1, 0, 0, 32'hFFFF8011, 0, 4'b1111, 32'h0);
    vecs[5]  = mk(3'b000, 2'b11, 32'h101, 32'h0, 3, 32'h80112233, 4, 3, 0, 0, 32'h00000022, 0, 4'b1111, 32'h0);
    vecs[6]  = mk(3'b011, 2'b00, 32'h201, 32'hA5, 1, 32'h77777777, 2, 1, 0, 0, 32'h00000022, 1, 4'b0010, 32'hA5A5A5A5);
    vecs[7]  = mk(3'b011, 2'b01, 32'h202, 32'h1234ABCD, 2, 32'h77777777, 3, 2, 0, 0, 32'h00000022, 1, 4'b1100, 32'hABCDABCD);
    vecs[8]  = mk(3'b010, 2'b10, 32'h204, 32'hCAFEF00D, 1, 32'h77777777, 2, 1, 0, 0, 32'h00000022, 1, 4'b1111, 32'hCAFEF00D);
    vecs[9]  = mk(3'b010, 2'b11, 32'h102, 32'h0, 1, 32'h11111111, 1, 0, 1, 0, 32'h00000022, 0, 4'b0000, 32'h0);
    vecs[10] = mk(3'b011, 2'b01, 32'h101, 32'hFFFF, 1, 32'h11111111, 1, 0, 1, 0, 32'h00000022, 1, 4'b0000, 32'h0);
    vecs[11] = mk(3'b010, 2'b11, 32'h300, 32'h0, 1, 32'h01234567, 2, 1, 0, 0, 32'h01234567, 0, 4'b1111, 32'h0);
    vecs[12] = mk(3'b101, 2'b11, 32'h010, 32'h0, 0, 32'h0, 5, 4, 0, 1, 32'h01234567, 0, 4'b1111, 32'h0);
    vecs[13] = mk(3'b010, 2'b11, 32'h008, 32'h0, 4, 32'h55AA55AA, 5, 4, 0, 0, 32'h55AA55AA, 0, 4'b1111, 32'h0);
    vecs[14] = mk(3'b000, 2'b11, 32'h000, 32'h0, 1, 32'h000000FF, 2, 1, 0, 0, 32'hFFFFFFFF, 0, 4'b1111, 32'h0);

    idle_inputs();
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    reset_n   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    chk("rst rdata", rdata, 32'h0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst misaligned", 32'(misaligned), 32'd0);
    chk("rst timeout", 32'(timeout), 32'd0);
    chk("rst bus_req", 32'(bus_req), 32'd0);
    chk("rst bus_we", 32'(bus_we), 32'd0);
    chk("rst bus_be", 32'(bus_be), 32'd0);
    chk("rst bus_addr", 32'(bus_addr), 32'd0);
    chk("rst bus_wdata", bus_wdata, 32'h0);

    for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

    // Invalid read_op codes start nothing.
    for (int k = 6; k < 8; k++) begin
      @(negedge clk);
      read_op = 3'(k); write_op = 2'b11; addr = 32'h400;
      @(negedge clk);
      idle_inputs();
      chk($sformatf("rop%0d busy", k), 32'(busy), 32'd0);
      chk($sformatf("rop%0d bus_req", k), 32'(bus_req), 32'd0);
      @(negedge clk);
      chk($sformatf("rop%0d done", k), 32'(done), 32'd0);
    end

    // An op presented during DONE is ignored.
    @(negedge clk);
    read_op = 3'b010; addr = 32'h001;
    @(negedge clk);
    chk("dn misaligned done", 32'(done), 32'd1);
    read_op = 3'b010; addr = 32'h500;
    @(negedge clk);
    idle_inputs();
    chk("dn op ignored busy", 32'(busy), 32'd0);
    chk("dn op ignored req", 32'(bus_req), 32'd0);
    chk("dn done pulse one cycle", 32'(done), 32'd0);

    // Reset during REQ drops bus_req after that edge.
    @(negedge clk);
    read_op = 3'b010; addr = 32'h600;
    @(negedge clk);
    idle_inputs();
    chk("mr req before reset", 32'(bus_req), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("mr bus_req", 32'(bus_req), 32'd0);
    chk("mr busy", 32'(busy), 32'd0);
    chk("mr rdata", rdata, 32'h0);

    // Stray ack in IDLE produces nothing.
    bus_ack = 1'b1;
    bus_rdata = 32'h99999999;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("stray done %0d", k), 32'(done), 32'd0);
      chk($sformatf("stray busy %0d", k), 32'(busy), 32'd0);
    end
    bus_ack = 1'b0;
    chk("stray rdata", rdata, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
